// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: the load strobe with value/blank going in, and the anode/segment/frame pins coming out.
// Latency: not applicable; this is wiring only.
// Backpressure: none. A load is always accepted, and the scan runs freely.
interface seg_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  // CPU / register side: drives the load strobe and observes the pins.
  modport master (
    output load, value, blank,
    input  an, seg, frame_done
  );

  // Scan driver side.
  modport slave (
    input  load, value, blank,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-seg scanner with per-slot dead time and tear-free double buffering.
// Latency: an/seg/frame_done are registered, so they lag the slot counter by 1 cycle. A load shows from the next frame.
// Backpressure: none. A load is captured every time it is strobed, and the last load in a frame wins.
module seg_scan_driver #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input logic           clk,
  input logic           rst,
  seg_scan_driver_if.slave bus
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   act_val;
  logic [3:0]    act_blank;
  logic [15:0]   pend_val;
  logic [3:0]    pend_blank;
  logic          pend_flag;
  logic          wrap_q;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  // With no dead time, the compare is dropped entirely rather than left as a constant-false test.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CW'(DEAD));
    end
  endgenerate

  // Slot counter and digit index: cnt wraps every DIV cycles and advances idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer. Loads park in the pending register, and the active copy only changes at the frame boundary.
  // A load landing exactly on the boundary bypasses the pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val    <= '0;
      act_blank  <= '0;
      pend_val   <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
    end else if (frame_end) begin
      if (bus.load) begin
        act_val   <= bus.value;
        act_blank <= bus.blank;
      end else if (pend_flag) begin
        act_val   <= pend_val;
        act_blank <= pend_blank;
      end
      pend_flag <= 1'b0;
    end else if (bus.load) begin
      pend_val   <= bus.value;
      pend_blank <= bus.blank;
      pend_flag  <= 1'b1;
    end
  end

  // Select the digit for the current slot, decode it, then force dark during dead time or when that digit is blanked.
  always_comb begin
    nib     = act_val[3:0];
    an_nxt  = 4'b1110;
    seg_nxt = 7'b1111111;
    case (idx)
      2'd0: begin nib = act_val[3:0];   an_nxt = 4'b1110; end
      2'd1: begin nib = act_val[7:4];   an_nxt = 4'b1101; end
      2'd2: begin nib = act_val[11:8];  an_nxt = 4'b1011; end
      default: begin nib = act_val[15:12]; an_nxt = 4'b0111; end
    endcase
    case (nib)
      4'h0: seg_nxt = 7'b1000000;
      4'h1: seg_nxt = 7'b1111001;
      4'h2: seg_nxt = 7'b0100100;
      4'h3: seg_nxt = 7'b0110000;
      4'h4: seg_nxt = 7'b0011001;
      4'h5: seg_nxt = 7'b0010010;
      4'h6: seg_nxt = 7'b0000010;
      4'h7: seg_nxt = 7'b1111000;
      4'h8: seg_nxt = 7'b0000000;
      4'h9: seg_nxt = 7'b0010000;
      4'hA: seg_nxt = 7'b0001000;
      4'hB: seg_nxt = 7'b0000011;
      4'hC: seg_nxt = 7'b1000110;
      4'hD: seg_nxt = 7'b0100001;
      4'hE: seg_nxt = 7'b0000110;
      default: seg_nxt = 7'b0001110;
    endcase
    if (in_dead || act_blank[idx]) begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
    end
  end

  // Output registers. frame_done is delayed one extra stage so it lines up with slot 0 / cnt=0 on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an         <= 4'b1111;
      bus.seg        <= 7'b1111111;
      bus.frame_done <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      wrap_q         <= frame_end;
      bus.frame_done <= wrap_q;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the board's 4-digit common-anode 7-segment display. Accepts a 16-bit hex value and per-digit blank mask through a load strobe. Cycles an active-low one-hot anode select, generating the matching active-low segment pattern for each slot, with a blanking dead time to suppress ghosting. Sits between the CPU's display register and the board's anode and segment pins. It is the producer of the anode/segment pair that the cathode selection logic consumes.

## Interface
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2
- DEAD, 16, blank cycles at the start of each slot; legal range 0 <= DEAD < DIV
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe; captures value and blank
- value  input  16  four hex digits; [3:0] is the rightmost digit
- blank  input  4  per-digit blank mask; bit i=1 forces digit i dark
- an  output  4  anode select, active-low one-hot, or 4'b1111 when blank
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- frame_done  output  1  one-cycle pulse after the last slot of digit 3

## Operation
- State:
  - slot counter cnt, 0..DIV-1
  - digit index idx, 0..3
  - active register act_val[15:0] and act_blank[3:0]
  - pending register pend_val and pend_blank, plus pend_flag
- Counting:
  - cnt increments every cycle.
  - At cnt==DIV-1, cnt wraps to 0 and idx increments mod 4.
- Digit mapping:
  - idx0 → an=4'b1110, act_val[3:0]
  - idx1 → an=4'b1101, act_val[7:4]
  - idx2 → an=4'b1011, act_val[11:8]
  - idx3 → an=4'b0111, act_val[15:12]
- Dead time: while cnt < DEAD, an=4'b1111 and seg=7'b1111111. With DEAD=0 there is no dead time.
- Blanking: if act_blank[idx]=1, an=4'b1111 and seg=7'b1111111 for the whole slot.
- Hex decode, in {g..a} order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Tear-free update:
  - load writes the pending register and sets pend_flag.
  - The active register changes only at the frame boundary, i.e. the cycle where cnt==DIV-1 and idx==3.
  - At the boundary, if pend_flag=1, active takes pending and pend_flag clears.
- Simultaneous events:
  - load on the boundary cycle: value and blank go directly into active that cycle, and pend_flag clears.
  - Multiple loads within one frame: the last load wins.
- Reset, including mid-frame: all outputs and state return to their reset values in the next cycle, and any pending load is discarded.

## Timing
- Reset values:
  - an=4'b1111, seg=7'b1111111, frame_done=0
  - cnt=0, idx=0, act_val=0, act_blank=0, pend_flag=0
- an, seg and frame_done are registered. They reflect the cnt/idx/active state of the previous cycle, i.e. 1-cycle latency.
- First cycle after rst deasserts: outputs are still at reset values. Digit 0 becomes visible DEAD+1 cycles after rst deasserts.
- Each slot lasts exactly DIV cycles: DEAD cycles dark, then DIV-DEAD cycles lit. A frame lasts 4·DIV cycles.
- frame_done goes high for exactly one cycle, the cycle in which an shows slot 0 of the next frame, cnt=0. First pulse: cycle 4·DIV+1 after reset release.
- Load-to-display latency: a new value appears in the first lit cycle of idx0 of the frame following the boundary. The maximum is 4·DIV+DEAD+1 cycles.
- cnt width is ceil(log2(DIV)); no other arithmetic.

## Test plan
- Reset scan, DIV=8, DEAD=2, no load:
  - an sequence: 1111×3, 1110×6, 1111×2, 1101×6, 1111×2, 1011×6, 1111×2, 0111×6, repeating.
  - seg=1000000 during lit cycles.
  - frame_done pulses every 32 cycles.
- Decode sweep: load value=16'h1234 mid-frame.
  - From the next frame: an 1110/seg 0011001, 1101/0110000, 1011/0100100, 0111/1111001.
  - Repeat with 16'hABCD, 16'h5E6F, 16'h7890 to cover all 16 glyphs.
- Tear-free update: load 16'hFFFF during idx2 of a frame showing 16'h0000.
  - idx2 and idx3 of that frame still show 1000000.
  - The next frame shows 0001110 on all digits.
- Boundary collision: load 16'h0008 exactly on the cycle cnt=7, idx=3.
  - The next idx0 lit slot shows seg=0000000. pend_flag=0 afterwards.
- Blanking with DEAD=0: load blank=4'b0101, value=16'h1111.
  - Slots for idx0 and idx2 show an=1111, seg=1111111 for the full slot.
  - Slots for idx1 and idx3 show an=1101 and 0111 with seg 1111001 for all 8 cycles.
- Mid-frame reset: assert rst for one cycle during idx1 with a load pending.
  - The next cycle shows all reset values.
  - The scan restarts at idx0 showing 1000000, and the pending value never appears.
